layer_pixel_writer: RTL and testbench

Write-side companion to the background layer reader. It accepts single-pixel plot requests (x, y, 4-bit palette index) over a valid/ready handshake and merges each one into the packed 4-bpp framebuffer (two pixels per byte) by read-modify-write on the byte-wide block-memory write port. Optionally it can also clear the whole buffer to one palette index. It sits between game logic and the framebuffer RAM; the display path reads the same RAM on the other port.

---
 rtl/layer_pixel_writer_if.sv | 39 +++
 rtl/layer_pixel_writer.sv | 152 +++++++++++++++
 tb/tb_layer_pixel_writer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_pixel_writer_if.sv
// layer_pixel_writer_if: plot-request handshake, status and framebuffer RAM
// port of the layer pixel writer, bundled for one connection.
//   slave  modport : the writer block (accepts plots, drives the RAM port)
//   master modport : game logic / RAM side (issues plots, returns read data)
interface layer_pixel_writer_if;
    localparam int unsigned X_W    = 9;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned C_W    = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // plot request handshake
    logic              in_valid;
    logic              in_ready;
    logic [X_W-1:0]    in_x;
    logic [Y_W-1:0]    in_y;
    logic [C_W-1:0]    in_color;
    // full-buffer clear request
    logic              clear_req;
    logic [C_W-1:0]    clear_color;
    // status
    logic              busy;
    logic              err_oob;
    // byte-wide framebuffer RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_x, in_y, in_color, clear_req, clear_color, mem_rdata,
        output in_ready, busy, err_oob, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output in_valid, in_x, in_y, in_color, clear_req, clear_color, mem_rdata,
        input  in_ready, busy, err_oob, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/layer_pixel_writer.sv
// layer_pixel_writer: merges single-pixel plot requests into a packed 4-bpp
// framebuffer (two pixels per byte, even pixel in [3:0]) by read-modify-write
// on a byte-wide RAM port. Optional full-buffer clear when FB_WRITER_CLEAR_EN
// is defined; without it clear_req/clear_color are accepted but ignored.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready/in_x/in_y/in_color plot handshake,
//                 clear_req/clear_color, busy, err_oob,
//                 mem_addr/mem_we/mem_wdata/mem_rdata RAM port
// Parameters: H_RES, V_RES framebuffer size; RD_LAT RAM read latency (1 or 2).
module layer_pixel_writer #(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 240,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    layer_pixel_writer_if.slave  bus
);
    localparam int unsigned PIX_W    = 17;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned C_W      = 4;
`ifdef FB_WRITER_CLEAR_EN
    localparam int unsigned CLR_LAST = H_RES * V_RES / 2 - 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_WR
`ifdef FB_WRITER_CLEAR_EN
        , S_CLR
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;     // RMW byte address, or clear counter
    logic                nib_q, nib_d;       // 1: high nibble
    logic [C_W-1:0]      color_q, color_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;   // clear pattern; zero otherwise
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [PIX_W-1:0]    pix;
    logic                oob;
    logic                clr_block;
    logic [DATA_W-1:0]   merged;

    // pixel index and bounds check on the raw request
    assign pix = PIX_W'(bus.in_y) * PIX_W'(H_RES) + PIX_W'(bus.in_x);
    assign oob = (32'(bus.in_x) >= H_RES) || (32'(bus.in_y) >= V_RES);

`ifdef FB_WRITER_CLEAR_EN
    assign clr_block = bus.clear_req;
`else
    logic unused_clear;
    assign unused_clear = ^{bus.clear_req, bus.clear_color};
    assign clr_block    = 1'b0;
`endif

    // ready is held low during reset even though state already reads IDLE
    assign bus.in_ready = rst_n && (state_q == S_IDLE) && !clr_block;

    // replace only the addressed nibble of the byte just read
    assign merged = nib_q ? {color_q, bus.mem_rdata[3:0]}
                          : {bus.mem_rdata[7:4], color_q};

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = (state_q == S_WR) ? merged : wdata_q;
    assign bus.busy      = busy_q;
    assign bus.err_oob   = err_q;

    // next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nib_d   = nib_q;
        color_d = color_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
`ifdef FB_WRITER_CLEAR_EN
                if (bus.clear_req) begin
                    state_d = S_CLR;
                    addr_d  = '0;
                    wdata_d = {bus.clear_color, bus.clear_color};
                end else
`endif
                if (bus.in_valid) begin
                    if (oob) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                        addr_d  = pix[PIX_W-1:1];
                        nib_d   = pix[0];
                        color_d = bus.in_color;
                    end
                end
            end
            S_RD:    state_d = (RD_LAT > 1) ? S_WT : S_WR;
            S_WT:    state_d = S_WR;   // RD_LAT is 1 or 2, so one wait cycle
            S_WR:    state_d = S_IDLE;
`ifdef FB_WRITER_CLEAR_EN
            S_CLR: begin
                if (addr_q == ADDR_W'(CLR_LAST)) begin
                    state_d = S_IDLE;
                    wdata_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef FB_WRITER_CLEAR_EN
        we_d = (state_d == S_WR) || (state_d == S_CLR);
`else
        we_d = (state_d == S_WR);
`endif
        busy_d = (state_d != S_IDLE);
    end

    // state and output registers; reset abandons any partial operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            nib_q   <= 1'b0;
            color_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nib_q   <= nib_d;
            color_q <= color_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_layer_pixel_writer.sv
// tb_layer_pixel_writer: two writer instances (RD_LAT=1 and RD_LAT=2), each
// with a byte RAM model, a transaction-level reference model of expected
// outputs checked every cycle, and directed plot/clear/reset scenarios.
`timescale 1ns/1ps
module tb_layer_pixel_writer;
    localparam int unsigned H     = 320;
    localparam int unsigned V     = 240;
    localparam int unsigned NBYTE = H * V / 2;
`ifdef FB_WRITER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_PLOT = 1;
    localparam int M_CLR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // stimulus
    logic       rst_n  [2];
    logic       vld_s  [2];
    logic [8:0] x_s    [2];
    logic [7:0] y_s    [2];
    logic [3:0] col_s  [2];
    logic       clr_s  [2];
    logic [3:0] ccol_s [2];
    logic        pre_en   [2];
    logic [15:0] pre_addr [2];
    logic [7:0]  pre_data [2];
    // observed
    logic        rdy_s   [2];
    logic        busy_s  [2];
    logic        err_s   [2];
    logic [15:0] addr_s  [2];
    logic        we_s    [2];
    logic [7:0]  wdata_s [2];
    logic [7:0]  rdata_s [2];

    layer_pixel_writer_if bus0 ();
    layer_pixel_writer_if bus1 ();

    layer_pixel_writer #(.H_RES(H), .V_RES(V), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .bus(bus0));
    layer_pixel_writer #(.H_RES(H), .V_RES(V), .RD_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .bus(bus1));

    assign bus0.in_valid    = vld_s[0];
    assign bus0.in_x        = x_s[0];
    assign bus0.in_y        = y_s[0];
    assign bus0.in_color    = col_s[0];
    assign bus0.clear_req   = clr_s[0];
    assign bus0.clear_color = ccol_s[0];
    assign bus0.mem_rdata   = rdata_s[0];
    assign rdy_s[0]   = bus0.in_ready;
    assign busy_s[0]  = bus0.busy;
    assign err_s[0]   = bus0.err_oob;
    assign addr_s[0]  = bus0.mem_addr;
    assign we_s[0]    = bus0.mem_we;
    assign wdata_s[0] = bus0.mem_wdata;

    assign bus1.in_valid    = vld_s[1];
    assign bus1.in_x        = x_s[1];
    assign bus1.in_y        = y_s[1];
    assign bus1.in_color    = col_s[1];
    assign bus1.clear_req   = clr_s[1];
    assign bus1.clear_color = ccol_s[1];
    assign bus1.mem_rdata   = rdata_s[1];
    assign rdy_s[1]   = bus1.in_ready;
    assign busy_s[1]  = bus1.busy;
    assign err_s[1]   = bus1.err_oob;
    assign addr_s[1]  = bus1.mem_addr;
    assign we_s[1]    = bus1.mem_we;
    assign wdata_s[1] = bus1.mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // RAM models: controls captured mid-cycle, applied at the clock edge
    logic [7:0] ram [2][NBYTE];
    logic [7:0] rd1 [2];
    logic [7:0] rd2 [2];
    assign rdata_s[0] = rd1[0];
    assign rdata_s[1] = rd2[1];

    initial begin
        logic        c_we [2];
        logic [15:0] c_ad [2];
        logic [7:0]  c_wd [2];
        logic        c_pe [2];
        logic [15:0] c_pa [2];
        logic [7:0]  c_pd [2];
        for (int k = 0; k < 2; k++) begin
            rd1[k] = 8'h00;
            rd2[k] = 8'h00;
            for (int i = 0; i < int'(NBYTE); i++) ram[k][i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                c_we[k] = we_s[k];  c_ad[k] = addr_s[k]; c_wd[k] = wdata_s[k];
                c_pe[k] = pre_en[k]; c_pa[k] = pre_addr[k]; c_pd[k] = pre_data[k];
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (c_pe[k]) ram[k][c_pa[k]] = c_pd[k];
                rd2[k] = rd1[k];
                rd1[k] = (int'(c_ad[k]) < int'(NBYTE)) ? ram[k][c_ad[k]] : 8'h00;
                if (c_we[k] && int'(c_ad[k]) < int'(NBYTE)) ram[k][c_ad[k]] = c_wd[k];
            end
        end
    end

    // reference model: one operation at a time, per-cycle expected outputs
    int          mode [2];
    int          step [2];
    int          cidx [2];
    int          m_addr [2];
    logic        m_nib [2];
    logic [3:0]  m_col [2];
    logic        m_err [2];
    logic [7:0]  gold [2][NBYTE];
    int          wr_cnt [2];
    int          busy_cnt [2];
    int          err_cnt [2];

    initial begin
        logic       e_ready, e_busy, e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_data, g;
        int          lat, p;
        for (int k = 0; k < 2; k++) begin
            mode[k] = M_IDLE; step[k] = 0; cidx[k] = 0; m_addr[k] = 0;
            m_nib[k] = 1'b0; m_col[k] = 4'h0; m_err[k] = 1'b0;
            wr_cnt[k] = 0; busy_cnt[k] = 0; err_cnt[k] = 0;
            for (int i = 0; i < int'(NBYTE); i++) gold[k][i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                lat = k + 1;
                if (we_s[k])   wr_cnt[k]++;
                if (busy_s[k]) busy_cnt[k]++;
                if (err_s[k])  err_cnt[k]++;
                if (!rst_n[k]) begin
                    chk("rst_we",    32'(we_s[k]),    32'h0);
                    chk("rst_addr",  32'(addr_s[k]),  32'h0);
                    chk("rst_wdata", 32'(wdata_s[k]), 32'h0);
                    chk("rst_busy",  32'(busy_s[k]),  32'h0);
                    chk("rst_err",   32'(err_s[k]),   32'h0);
                    chk("rst_ready", 32'(rdy_s[k]),   32'h0);
                    mode[k]  = M_IDLE;
                    m_err[k] = 1'b0;
                end else begin
                    e_ready = (mode[k] == M_IDLE) && !(CLR_EN && clr_s[k]);
                    e_busy  = (mode[k] != M_IDLE);
                    e_we    = (mode[k] == M_CLR) || (mode[k] == M_PLOT && step[k] == lat + 1);
                    e_addr  = (mode[k] == M_CLR) ? 16'(cidx[k]) : 16'(m_addr[k]);
                    g       = gold[k][m_addr[k]];
                    e_data  = (mode[k] == M_CLR) ? {m_col[k], m_col[k]}
                            : (m_nib[k] ? {m_col[k], g[3:0]} : {g[7:4], m_col[k]});
                    chk("ready", 32'(rdy_s[k]),  32'(e_ready));
                    chk("busy",  32'(busy_s[k]), 32'(e_busy));
                    chk("we",    32'(we_s[k]),   32'(e_we));
                    chk("err",   32'(err_s[k]),  32'(m_err[k]));
                    if (mode[k] == M_PLOT && step[k] == 1)
                        chk("rd_addr", 32'(addr_s[k]), 32'(e_addr));
                    if (e_we) begin
                        chk("wr_addr", 32'(addr_s[k]),  32'(e_addr));
                        chk("wr_data", 32'(wdata_s[k]), 32'(e_data));
                    end
                    if (pre_en[k]) gold[k][pre_addr[k]] = pre_data[k];
                    m_err[k] = 1'b0;
                    case (mode[k])
                        M_IDLE: begin
                            if (CLR_EN && clr_s[k]) begin
                                mode[k] = M_CLR; cidx[k] = 0; m_col[k] = ccol_s[k];
                            end else if (vld_s[k]) begin
                                if (int'(x_s[k]) >= int'(H) || int'(y_s[k]) >= int'(V)) begin
                                    m_err[k] = 1'b1;
                                end else begin
                                    p = int'(y_s[k]) * int'(H) + int'(x_s[k]);
                                    mode[k] = M_PLOT; step[k] = 1;
                                    m_addr[k] = p / 2; m_nib[k] = (p % 2) == 1;
                                    m_col[k] = col_s[k];
                                end
                            end
                        end
                        M_PLOT: begin
                            if (step[k] == lat + 1) begin
                                gold[k][m_addr[k]] = e_data;
                                mode[k] = M_IDLE;
                            end else begin
                                step[k]++;
                            end
                        end
                        default: begin
                            gold[k][cidx[k]] = e_data;
                            if (cidx[k] == int'(NBYTE) - 1) mode[k] = M_IDLE;
                            else cidx[k]++;
                        end
                    endcase
                end
            end
        end
    end

    // stimulus helpers; all start and end just after a rising edge
    task automatic preload(input int k, input int a, input logic [7:0] d);
        pre_en[k] = 1'b1; pre_addr[k] = 16'(a); pre_data[k] = d;
        @(posedge clk); #1;
        pre_en[k] = 1'b0;
    endtask

    // returns the cycle (acceptance = cycle 0) in which in_ready is high again
    task automatic plot(input int k, input int x, input int y, input logic [3:0] c,
                        output int lat);
        bit ok;
        int n;
        vld_s[k] = 1'b1; x_s[k] = 9'(x); y_s[k] = 8'(y); col_s[k] = c;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy_s[k]) begin ok = 1'b1; break; end
        end
        chk("accept", 32'(ok), 32'h1);
        @(posedge clk); #1;
        vld_s[k] = 1'b0;
        ok = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy_s[k]) begin ok = 1'b1; break; end
            n++;
        end
        chk("ready_return", 32'(ok), 32'h1);
        lat = n;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, w0, b0, e0, n;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; vld_s[k] = 1'b0; x_s[k] = '0; y_s[k] = '0; col_s[k] = '0;
            clr_s[k] = 1'b0; ccol_s[k] = '0; pre_en[k] = 1'b0; pre_addr[k] = '0; pre_data[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // basic plot into a zero byte: even pixel -> low nibble
        w0 = wr_cnt[0]; b0 = busy_cnt[0];
        plot(0, 4, 0, 4'hA, lat);
        chk("p1_lat",   32'(lat), 32'd3);
        chk("p1_byte",  32'(ram[0][2]), 32'h0A);
        chk("p1_nwr",   32'(wr_cnt[0] - w0), 32'd1);
        chk("p1_nbusy", 32'(busy_cnt[0] - b0), 32'd2);

        // odd pixel -> high nibble, low nibble preserved
        preload(0, 2, 8'h5C);
        plot(0, 5, 0, 4'h3, lat);
        chk("p2_byte", 32'(ram[0][2]), 32'h3C);

        // out-of-bounds in x and in y
        w0 = wr_cnt[0]; e0 = err_cnt[0];
        plot(0, 320, 10, 4'h1, lat);
        chk("oobx_lat", 32'(lat), 32'd1);
        plot(0, 0, 240, 4'h1, lat);
        chk("ooby_lat", 32'(lat), 32'd1);
        chk("oob_nwr",  32'(wr_cnt[0] - w0), 32'd0);
        chk("oob_nerr", 32'(err_cnt[0] - e0), 32'd2);

        // last pixel of the buffer
        preload(0, 38399, 8'h0E);
        plot(0, 319, 239, 4'hF, lat);
        chk("corner_byte", 32'(ram[0][38399]), 32'hFE);

        // reset during RD: write abandoned
        w0 = wr_cnt[0];
        vld_s[0] = 1'b1; x_s[0] = 9'd10; y_s[0] = 8'd1; col_s[0] = 4'h5;
        @(negedge clk);
        @(posedge clk); #1;
        vld_s[0] = 1'b0;
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        chk("rstrd_nwr",  32'(wr_cnt[0] - w0), 32'd0);
        chk("rstrd_byte", 32'(ram[0][165]), 32'h00);
        plot(0, 10, 1, 4'h5, lat);
        chk("rstrd_after", 32'(ram[0][165]), 32'h05);

`ifdef FB_WRITER_CLEAR_EN
        // clear wins over a simultaneous plot; plot is taken afterwards
        w0 = wr_cnt[0];
        clr_s[0] = 1'b1; ccol_s[0] = 4'h7;
        vld_s[0] = 1'b1; x_s[0] = 9'd2; y_s[0] = 8'd0; col_s[0] = 4'h9;
        @(posedge clk); #1;
        clr_s[0] = 1'b0;
        n = 1; ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (rdy_s[0]) begin ok = 1'b1; break; end
            n++;
        end
        chk("clr_done", 32'(ok), 32'h1);
        chk("clr_idle_cycle", 32'(n), 32'd38401);
        @(posedge clk); #1;
        vld_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_nwr",   32'(wr_cnt[0] - w0), 32'd38401);
        chk("clr_first", 32'(ram[0][0]), 32'h77);
        chk("clr_plot",  32'(ram[0][1]), 32'h79);
        chk("clr_last",  32'(ram[0][38399]), 32'h77);

        // reset in the middle of a clear
        clr_s[0] = 1'b1; ccol_s[0] = 4'h3;
        @(posedge clk); #1;
        clr_s[0] = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        chk("rstclr_in",  32'(ram[0][48]), 32'h33);
        chk("rstclr_out", 32'(ram[0][49]), 32'h77);
        plot(0, 2, 0, 4'hC, lat);
        chk("rstclr_after", 32'(ram[0][1]), 32'h3C);
`endif

        // RD_LAT=2: both nibbles of one byte, 4 cycles per plot
        plot(1, 0, 3, 4'h6, lat);
        chk("l2_lat_a", 32'(lat), 32'd4);
        plot(1, 1, 3, 4'hB, lat);
        chk("l2_lat_b", 32'(lat), 32'd4);
        chk("l2_byte",  32'(ram[1][480]), 32'hB6);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
